// File: rtl/aes_word_sequencer.sv
// Feeds 32-bit words into 128-bit AES key/text blocks, sequences the core's
// kld/kdone and ld/done handshakes, and streams each result back out as four words.
module aes_word_sequencer #(
  parameter int DONE_TIMEOUT = 64,
  parameter int CNT_W        = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_is_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         core_kld,
  output logic [127:0] core_key,
  input  logic         core_kdone,
  output logic         core_ld,
  output logic [127:0] core_text_in,
  input  logic         core_done,
  input  logic [127:0] core_text_out,
  output logic         err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_KLOAD,
    S_KWAIT,
    S_TLOAD,
    S_TWAIT,
    S_DRAIN
  } state_t;

  state_t         state_reg;
  logic           is_key_reg;
  logic [1:0]     word_cnt_reg;
  logic [95:0]    asm_reg;
  logic [127:0]   key_reg;
  logic [127:0]   text_reg;
  logic [127:0]   result_reg;
  logic           key_valid_reg;
  logic [CNT_W-1:0] tmo_cnt_reg;
  logic           err_reg;
  logic           kld_reg;
  logic           ld_reg;
  logic           in_ready_reg;
  logic           out_valid_reg;
  logic           out_last_reg;
  logic [31:0]    out_data_reg;
  logic [1:0]     out_idx_reg;

  logic           in_fire;
  logic           out_fire;
  logic           tmo_hit;
  logic [31:0]    result_words [4];

  assign in_fire  = in_valid && in_ready_reg;
  assign out_fire = out_valid_reg && out_ready;
  assign tmo_hit  = (tmo_cnt_reg == CNT_W'(DONE_TIMEOUT - 1));

  for (genvar gi = 0; gi < 4; gi++) begin : g_words
    assign result_words[gi] = result_reg[127-32*gi -: 32];
  end

  // Words 0-2 wait in asm_reg so a partial or dropped burst never disturbs
  // the key/text currently presented to the core.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      is_key_reg    <= 1'b0;
      word_cnt_reg  <= 2'd0;
      asm_reg       <= '0;
      key_reg       <= '0;
      text_reg      <= '0;
      result_reg    <= '0;
      key_valid_reg <= 1'b0;
      tmo_cnt_reg   <= '0;
      err_reg       <= 1'b0;
      kld_reg       <= 1'b0;
      ld_reg        <= 1'b0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
      out_idx_reg   <= 2'd0;
    end else begin
      kld_reg <= 1'b0;
      ld_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          in_ready_reg <= 1'b1;
          if (in_fire) begin
            is_key_reg     <= in_is_key;
            asm_reg[95:64] <= in_data;
            word_cnt_reg   <= 2'd1;
            state_reg      <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (in_fire) begin
            if (word_cnt_reg != 2'd3) begin
              asm_reg[95-32*word_cnt_reg -: 32] <= in_data;
              word_cnt_reg <= word_cnt_reg + 2'd1;
            end else begin
              word_cnt_reg <= 2'd0;
              if (is_key_reg) begin
                key_reg      <= {asm_reg, in_data};
                kld_reg      <= 1'b1;
                in_ready_reg <= 1'b0;
                state_reg    <= S_KLOAD;
              end else if (key_valid_reg) begin
                text_reg     <= {asm_reg, in_data};
                ld_reg       <= 1'b1;
                in_ready_reg <= 1'b0;
                state_reg    <= S_TLOAD;
              end else begin
                err_reg   <= 1'b1;
                state_reg <= S_IDLE;
              end
            end
          end
        end
        S_KLOAD: begin
          tmo_cnt_reg <= '0;
          state_reg   <= S_KWAIT;
        end
        S_KWAIT: begin
          if (core_kdone) begin
            key_valid_reg <= 1'b1;
            in_ready_reg  <= 1'b1;
            state_reg     <= S_IDLE;
          end else if (tmo_hit) begin
            err_reg       <= 1'b1;
            key_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= S_IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        S_TLOAD: begin
          tmo_cnt_reg <= '0;
          state_reg   <= S_TWAIT;
        end
        S_TWAIT: begin
          if (core_done) begin
            result_reg    <= core_text_out;
            out_data_reg  <= core_text_out[127:96];
            out_valid_reg <= 1'b1;
            out_last_reg  <= 1'b0;
            out_idx_reg   <= 2'd0;
            state_reg     <= S_DRAIN;
          end else if (tmo_hit) begin
            err_reg      <= 1'b1;
            in_ready_reg <= 1'b1;
            state_reg    <= S_IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        S_DRAIN: begin
          if (out_fire) begin
            if (out_idx_reg == 2'd3) begin
              out_valid_reg <= 1'b0;
              out_last_reg  <= 1'b0;
              in_ready_reg  <= 1'b1;
              state_reg     <= S_IDLE;
            end else begin
              out_idx_reg  <= out_idx_reg + 2'd1;
              out_data_reg <= result_words[out_idx_reg + 2'd1];
              out_last_reg <= (out_idx_reg == 2'd2);
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = in_ready_reg;
  assign out_valid    = out_valid_reg;
  assign out_data     = out_data_reg;
  assign out_last     = out_last_reg;
  assign core_kld     = kld_reg;
  assign core_ld      = ld_reg;
  assign core_key     = key_reg;
  assign core_text_in = text_reg;
  assign err          = err_reg;

endmodule

// File: tb/tb_aes_word_sequencer.sv
// Directed bench for aes_word_sequencer with a small behavioural AES core responder.
module tb_aes_word_sequencer;

  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] TXT = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RES = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_is_key;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic         core_kld;
  logic [127:0] core_key;
  logic         core_kdone;
  logic         core_ld;
  logic [127:0] core_text_in;
  logic         core_done;
  logic [127:0] core_text_out;
  logic         err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int out_hs = 0;
  int kld_count = 0;
  int ld_count = 0;
  int kd_cnt = 0;
  int d_cnt = 0;
  bit done_en = 1'b1;
  logic [31:0] res_w [4];

  aes_word_sequencer #(.DONE_TIMEOUT(64), .CNT_W(7)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_is_key(in_is_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .core_kld(core_kld), .core_key(core_key), .core_kdone(core_kdone),
    .core_ld(core_ld), .core_text_in(core_text_in), .core_done(core_done),
    .core_text_out(core_text_out), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (out_valid && out_ready) out_hs <= out_hs + 1;
  end

  // Core responder: kdone/done three cycles after each load pulse.
  initial begin
    core_kdone = 1'b0;
    core_done = 1'b0;
    core_text_out = RES;
    forever begin
      @(negedge clk);
      core_kdone = 1'b0;
      core_done = 1'b0;
      if (kd_cnt > 0) begin
        kd_cnt--;
        if (kd_cnt == 0) core_kdone = 1'b1;
      end
      if (d_cnt > 0) begin
        d_cnt--;
        if (d_cnt == 0) core_done = 1'b1;
      end
      if (core_kld) begin
        kld_count++;
        kd_cnt = 3;
      end
      if (core_ld) begin
        ld_count++;
        if (done_en) d_cnt = 3;
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input bit k);
    int t = 0;
    in_valid = 1'b1;
    in_data = d;
    in_is_key = k;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_word_timeout word=%h in_ready=%b required 1", d, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] blk, input bit k);
    for (int i = 0; i < 4; i++) send_word(blk[127-32*i -: 32], k);
  endtask

  task automatic collect(input int stall);
    int t = 0;
    int hs0;
    hs0 = out_hs;
    out_ready = 1'b0;
    while (!out_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL out_valid_wait got=%b required 1", out_valid);
    end
    for (int i = 0; i < stall; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== res_w[0] || out_last !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cycle=%0d got valid=%b data=%h last=%b required 1 %h 0",
                 i, out_valid, out_data, out_last, res_w[0]);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== res_w[i] || out_last !== (i == 3)) begin
        errors++;
        $display("FAIL out_word%0d got valid=%b data=%h last=%b required 1 %h %b",
                 i, out_valid, out_data, out_last, res_w[i], (i == 3));
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || (out_hs - hs0) != 4) begin
      errors++;
      $display("FAIL drain_end got valid=%b handshakes=%0d required 0 4", out_valid, out_hs - hs0);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_last, core_kld, core_ld, err} !== 6'b0 ||
        out_data !== 32'h0 || core_key !== 128'h0 || core_text_in !== 128'h0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b ov=%b last=%b kld=%b ld=%b err=%b data=%h required all 0",
               in_ready, out_valid, out_last, core_kld, core_ld, err, out_data);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got=%b required 1", in_ready);
    end
  endtask

  task automatic test_key_text;
    int k0;
    int l0;
    k0 = kld_count;
    l0 = ld_count;
    send_block(KEY, 1'b1);
    checks++;
    if (core_kld !== 1'b1 || core_key !== KEY) begin
      errors++;
      $display("FAIL kld_pulse got kld=%b key=%h required 1 %h", core_kld, core_key, KEY);
    end
    send_block(TXT, 1'b0);
    checks++;
    if (core_ld !== 1'b1 || core_text_in !== TXT) begin
      errors++;
      $display("FAIL ld_pulse got ld=%b text=%h required 1 %h", core_ld, core_text_in, TXT);
    end
    collect(0);
    checks++;
    if ((kld_count - k0) != 1 || (ld_count - l0) != 1 || err !== 1'b0 || core_key !== KEY) begin
      errors++;
      $display("FAIL key_text_pulses got kld=%0d ld=%0d err=%b required 1 1 0",
               kld_count - k0, ld_count - l0, err);
    end
  endtask

  task automatic test_backpressure;
    send_block(TXT, 1'b0);
    collect(5);
  endtask

  task automatic test_timeout;
    done_en = 1'b0;
    send_block(TXT, 1'b0);
    checks++;
    if (core_ld !== 1'b1) begin
      errors++;
      $display("FAIL timeout_ld got=%b required 1", core_ld);
    end
    repeat (64) @(posedge clk);
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early got err=%b ready=%b required 0 0", err, in_ready);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fire got err=%b ready=%b required 1 1", err, in_ready);
    end
    done_en = 1'b1;
    send_block(TXT, 1'b0);
    checks++;
    if (core_ld !== 1'b1) begin
      errors++;
      $display("FAIL timeout_key_kept got ld=%b required 1", core_ld);
    end
    collect(0);
  endtask

  task automatic test_reset_mid_burst;
    send_word(TXT[127:96], 1'b0);
    send_word(TXT[95:64], 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_last, core_kld, core_ld, err} !== 6'b0 ||
        out_data !== 32'h0 || core_key !== 128'h0 || core_text_in !== 128'h0) begin
      errors++;
      $display("FAIL midreset_outputs got ready=%b ov=%b last=%b kld=%b ld=%b err=%b required all 0",
               in_ready, out_valid, out_last, core_kld, core_ld, err);
    end
    rst = 1'b1;
    @(negedge clk);
    test_key_text();
  endtask

  task automatic test_text_no_key;
    int l0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    l0 = ld_count;
    send_block(TXT, 1'b0);
    checks++;
    if (err !== 1'b1 || in_ready !== 1'b1 || core_ld !== 1'b0) begin
      errors++;
      $display("FAIL nokey_err got err=%b ready=%b ld=%b required 1 1 0", err, in_ready, core_ld);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (ld_count != l0 || core_text_in !== 128'h0) begin
      errors++;
      $display("FAIL nokey_dropped got ld_pulses=%0d text=%h required 0 0", ld_count - l0, core_text_in);
    end
  endtask

  initial begin
    res_w[0] = RES[127:96];
    res_w[1] = RES[95:64];
    res_w[2] = RES[63:32];
    res_w[3] = RES[31:0];
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = 32'h0;
    in_is_key = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_key_text();
    test_backpressure();
    test_timeout();
    test_reset_mid_burst();
    test_text_no_key();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
